upg_mode_ctrl: RTL and testbench
================================

UPG_MODE_CTRL -- requirements
Module: upg_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, cycles start_pg must be stable before its debounced level changes.
REQ-002 Parameter ARM_CYCLES, default 2, cycles of CPU reset before the UART programmer is released.
REQ-003 Parameter DRAIN_CYCLES, default 4, cycles of CPU reset held after programming completes.
REQ-004 Parameter ADDR_W, default 14, memory word-address width.
REQ-005 Parameter DATA_W, default 32, memory data width.
REQ-006 fpga_clk  in  1  single system clock; all state updates on its rising edge.
REQ-007 fpga_rst_n  in  1  asynchronous, active-low reset.
REQ-008 start_pg  in  1  raw, asynchronous program-mode button, active-high.
REQ-009 upg_done  in  1  one-cycle pulse from the UART programmer marking end of download.
REQ-010 upg_wen / upg_adr / upg_dat  in  1 / ADDR_W / DATA_W  UART programmer write port.
REQ-011 cpu_wen / cpu_adr / cpu_dat  in  1 / ADDR_W / DATA_W  CPU store port.
REQ-012 mem_wen / mem_adr / mem_dat  out  1 / ADDR_W / DATA_W  shared memory write port.
REQ-013 upg_rst  out  1  active-high hold of the UART programmer.
REQ-014 cpu_rst  out  1  active-high CPU reset.
REQ-015 pg_mode  out  1  high while the UART programmer owns memory.

Function
REQ-016 start_pg SHALL pass through a 2-FF synchronizer, then a counter that updates the debounced level only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-017 A press event SHALL be a 0->1 transition of the debounced level, lasting one cycle.
REQ-018 The FSM SHALL have states RUN, ARM, PROG, DRAIN.
REQ-019 RUN: cpu_rst=0, upg_rst=1, pg_mode=0, mem port = CPU port; on a press event -> ARM.
REQ-020 ARM: cpu_rst=1, upg_rst=1, mem_wen=0; after ARM_CYCLES cycles -> PROG.
REQ-021 PROG: cpu_rst=1, upg_rst=0, pg_mode=1, mem port = UART port; on upg_done -> DRAIN.
REQ-022 DRAIN: cpu_rst=1, upg_rst=1, mem_wen=0; after DRAIN_CYCLES cycles -> RUN.
REQ-023 upg_rst, cpu_rst, pg_mode SHALL be registered and change in the same cycle as the state.
REQ-024 mem_* SHALL be combinational muxes selected by the registered state; cpu_wen SHALL never reach mem_wen outside RUN, and upg_wen SHALL never reach it outside PROG.
REQ-025 Press events in ARM, PROG, DRAIN SHALL be ignored; upg_done outside PROG SHALL be ignored.
REQ-026 Press event and upg_done in the same PROG cycle: upg_done wins (-> DRAIN).
REQ-027 The ARM/DRAIN counter SHALL be cleared on every state entry; ARM_CYCLES=0 or DRAIN_CYCLES=0 SHALL behave as 1.
REQ-028 If the button is still held on return to RUN, no new press event SHALL occur until a release and re-press.

Reset
REQ-029 While fpga_rst_n=0: state=RUN, cpu_rst=1, upg_rst=1, pg_mode=0, debounced level=0, counters=0, synchronizer=0.
REQ-030 On the first rising edge after reset release, cpu_rst SHALL go to 0.
REQ-031 Reset asserted in any state SHALL abort immediately; memory writes stop asynchronously (mem_wen=0 during reset).

Verification
REQ-032 Reset then idle: cpu_rst 1->0 one cycle after release; upg_rst=1, pg_mode=0, mem_wen follows cpu_wen.
REQ-033 Bounce: start_pg toggles every 3 cycles for 40 cycles, then settles low -> no state change; held high 16+ cycles -> ARM entered exactly once, cpu_rst=1.
REQ-034 Full cycle (ARM_CYCLES=2, DRAIN_CYCLES=4): press -> ARM 2 cycles -> PROG (upg_rst=0, mem_adr=upg_adr) -> upg_done pulse -> DRAIN 4 cycles with cpu_rst=1 -> RUN with cpu_rst=0.
REQ-035 Isolation: cpu_wen=1 throughout PROG -> mem_wen equals upg_wen only; upg_wen=1 in RUN -> mem_wen equals cpu_wen only.
REQ-036 Collision: press and upg_done in the same PROG cycle -> DRAIN next cycle; button held through DRAIN -> stays RUN.
REQ-037 Mid-PROG reset: fpga_rst_n low -> same-cycle upg_rst=1, cpu_rst=1, pg_mode=0, mem_wen=0; after release -> RUN.

Source files
------------

// File: rtl/upg_mode_ctrl.sv
// Program-mode controller: debounces the program button and hands the shared
// memory write port between the CPU and the UART programmer.
module upg_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ARM_CYCLES      = 2,
  parameter int DRAIN_CYCLES    = 4,
  parameter int ADDR_W          = 14,
  parameter int DATA_W          = 32
) (
  input  logic              fpga_clk,
  input  logic              fpga_rst_n,
  input  logic              start_pg,
  input  logic              upg_done,
  input  logic              upg_wen,
  input  logic [ADDR_W-1:0] upg_adr,
  input  logic [DATA_W-1:0] upg_dat,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_dat,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_dat,
  output logic              upg_rst,
  output logic              cpu_rst,
  output logic              pg_mode
);

  localparam int DB_N  = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int ARM_N = (ARM_CYCLES < 1) ? 1 : ARM_CYCLES;
  localparam int DRN_N = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int MAX_N = (ARM_N > DRN_N) ? ARM_N : DRN_N;
  localparam int DB_W  = $clog2(DB_N + 1);
  localparam int CW    = $clog2(MAX_N + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_N - 1);
  localparam logic [CW-1:0]   ARM_LAST = CW'(ARM_N - 1);
  localparam logic [CW-1:0]   DRN_LAST = CW'(DRN_N - 1);

  typedef enum logic [1:0] {
    RUN,
    ARM,
    PROG,
    DRAIN
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      sync;
  logic [DB_W-1:0] db_cnt;
  logic            db, db_q;
  logic            press;

  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], start_pg};
    end
  end

  // Level only flips after DB_N samples in a row disagree with it.
  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      db_cnt <= '0;
      db     <= 1'b0;
      db_q   <= 1'b0;
    end else begin
      db_q <= db;
      if (sync[1] == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= sync[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      RUN: begin
        if (press) begin
          state_n = ARM;
          cnt_n   = '0;
        end
      end
      ARM: begin
        if (cnt == ARM_LAST) begin
          state_n = PROG;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PROG: begin
        if (upg_done) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end
      end
      DRAIN: begin
        if (cnt == DRN_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = '0;
      end
    endcase
  end

  // Control outputs come from the next state so they move with it.
  always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      state   <= RUN;
      cnt     <= '0;
      cpu_rst <= 1'b1;
      upg_rst <= 1'b1;
      pg_mode <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cpu_rst <= (state_n != RUN);
      upg_rst <= (state_n != PROG);
      pg_mode <= (state_n == PROG);
    end
  end

  always_comb begin
    mem_wen = 1'b0;
    mem_adr = upg_adr;
    mem_dat = upg_dat;
    if (state == RUN) begin
      mem_wen = cpu_wen & fpga_rst_n;
      mem_adr = cpu_adr;
      mem_dat = cpu_dat;
    end else if (state == PROG) begin
      mem_wen = upg_wen & fpga_rst_n;
    end
  end

endmodule

// File: tb/tb_upg_mode_ctrl.sv
// Scoreboard bench for upg_mode_ctrl: a per-cycle reference model queues the
// expected outputs and a monitor compares them one step after each edge.
module tb_upg_mode_ctrl;

  localparam int DB = 16;
  localparam int AC = 2;
  localparam int DC = 4;
  localparam int P_RUN = 0, P_ARM = 1, P_PROG = 2, P_DRAIN = 3;

  logic        fpga_clk;
  logic        fpga_rst_n = 1'b0;
  logic        start_pg = 1'b0;
  logic        upg_done = 1'b0;
  logic        upg_wen = 1'b0;
  logic [13:0] upg_adr = '0;
  logic [31:0] upg_dat = '0;
  logic        cpu_wen = 1'b0;
  logic [13:0] cpu_adr = '0;
  logic [31:0] cpu_dat = '0;
  logic        mem_wen;
  logic [13:0] mem_adr;
  logic [31:0] mem_dat;
  logic        upg_rst, cpu_rst, pg_mode;

  upg_mode_ctrl dut (
    .fpga_clk(fpga_clk), .fpga_rst_n(fpga_rst_n),
    .start_pg(start_pg), .upg_done(upg_done),
    .upg_wen(upg_wen), .upg_adr(upg_adr), .upg_dat(upg_dat),
    .cpu_wen(cpu_wen), .cpu_adr(cpu_adr), .cpu_dat(cpu_dat),
    .mem_wen(mem_wen), .mem_adr(mem_adr), .mem_dat(mem_dat),
    .upg_rst(upg_rst), .cpu_rst(cpu_rst), .pg_mode(pg_mode)
  );

  initial begin
    fpga_clk = 1'b0;
    forever #5 fpga_clk = ~fpga_clk;
  end

  typedef struct {
    logic        cpu_rst;
    logic        upg_rst;
    logic        pg_mode;
    logic        wen;
    bit          chk;
    logic [13:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   rises = 0;

  // Reference model state
  int   m_phase;
  int   m_left;
  logic m_db;
  logic m_press;
  logic m_pipe[$];
  logic m_hist[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RUN;
    m_left  = 0;
    m_db    = 1'b0;
    m_press = 1'b0;
    m_pipe  = {1'b0, 1'b0};
    m_hist.delete();
    for (int i = 0; i < DB; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_edge(input logic sp, input logic done);
    logic seen, flip;
    case (m_phase)
      P_RUN: if (m_press) begin m_phase = P_ARM; m_left = AC; end
      P_ARM: begin
        m_left--;
        if (m_left <= 0) m_phase = P_PROG;
      end
      P_PROG: if (done) begin m_phase = P_DRAIN; m_left = DC; end
      default: begin
        m_left--;
        if (m_left <= 0) m_phase = P_RUN;
      end
    endcase
    seen = m_pipe.pop_front();
    m_pipe.push_back(sp);
    m_hist.push_back(seen);
    if (m_hist.size() > DB) void'(m_hist.pop_front());
    flip = 1'b1;
    foreach (m_hist[i]) if (m_hist[i] == m_db) flip = 1'b0;
    m_press = flip & ~m_db;
    if (flip) m_db = ~m_db;
  endtask

  task automatic step(input logic sp, input logic done,
                      input logic uw, input logic cw);
    exp_t e;
    @(negedge fpga_clk);
    start_pg = sp;
    upg_done = done;
    upg_wen  = uw;
    cpu_wen  = cw;
    upg_adr  = 14'($urandom);
    upg_dat  = $urandom;
    cpu_adr  = 14'($urandom);
    cpu_dat  = $urandom;
    model_edge(sp, done);
    e.cpu_rst = (m_phase != P_RUN);
    e.upg_rst = (m_phase != P_PROG);
    e.pg_mode = (m_phase == P_PROG);
    e.wen = (m_phase == P_RUN) ? cw : (m_phase == P_PROG) ? uw : 1'b0;
    e.chk = (m_phase == P_RUN) || (m_phase == P_PROG);
    e.adr = (m_phase == P_RUN) ? cpu_adr : upg_adr;
    e.dat = (m_phase == P_RUN) ? cpu_dat : upg_dat;
    sb.push_back(e);
  endtask

  task automatic rnd_step(input logic sp, input logic done);
    step(sp, done, 1'($urandom), 1'($urandom));
  endtask

  // Monitor: one expectation per active edge while out of reset.
  initial begin
    exp_t e;
    logic prev;
    prev = 1'b1;
    forever begin
      @(posedge fpga_clk);
      #1;
      if (prev === 1'b0 && cpu_rst === 1'b1) rises++;
      prev = cpu_rst;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("cpu_rst", 32'(cpu_rst), 32'(e.cpu_rst));
        check("upg_rst", 32'(upg_rst), 32'(e.upg_rst));
        check("pg_mode", 32'(pg_mode), 32'(e.pg_mode));
        check("mem_wen", 32'(mem_wen), 32'(e.wen));
        if (e.chk) begin
          check("mem_adr", 32'(mem_adr), 32'(e.adr));
          check("mem_dat", mem_dat, e.dat);
        end
      end
    end
  end

  task automatic hold_reset_and_check(input string tag);
    @(posedge fpga_clk);
    #2;
    cpu_wen = 1'b1;
    upg_wen = 1'b1;
    fpga_rst_n = 1'b0;
    #1;
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_upg_rst"}, 32'(upg_rst), 32'd1);
    check({tag, "_pg_mode"}, 32'(pg_mode), 32'd0);
    check({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
    model_reset();
    repeat (2) @(posedge fpga_clk);
    #2;
    fpga_rst_n = 1'b1;
  endtask

  initial begin
    bit hit;
    model_reset();
    hold_reset_and_check("rst_init");

    // Idle run: CPU owns the port
    repeat (10) rnd_step(1'b0, 1'b0);

    // Bounce every 3 cycles, then settle low
    rises = 0;
    for (int i = 0; i < 40; i++) rnd_step(1'((i / 3) % 2), 1'b0);
    repeat (20) rnd_step(1'b0, 1'b0);
    check("bounce_no_arm", 32'(rises), 32'd0);

    // Clean press held well past the debounce window
    repeat (25) rnd_step(1'b1, 1'b0);
    check("arm_once", 32'(rises), 32'd1);

    // PROG with CPU hammering writes
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'($urandom), 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (DC + 6) step(1'b0, 1'b0, 1'b1, 1'($urandom));

    // Second session; retrigger the button inside PROG and collide with done
    repeat (25) rnd_step(1'b1, 1'b0);
    repeat (25) rnd_step(1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (m_press && m_phase == P_PROG) hit = 1'b1;
      rnd_step(1'b1, hit);
    end
    check("collision_reached", 32'(hit), 32'd1);
    repeat (DC + 12) rnd_step(1'b1, 1'b0);
    repeat (20) rnd_step(1'b0, 1'b0);

    // Randomised button runs with stray done pulses
    for (int n = 0; n < 500; ) begin
      logic v;
      int len;
      v = 1'($urandom);
      len = $urandom_range(1, 30);
      for (int k = 0; k < len; k++) rnd_step(v, 1'($urandom_range(0, 7) == 0));
      n += len;
    end

    // Force into PROG, then reset mid-session
    repeat (30) rnd_step(1'b0, 1'b0);
    repeat (25) rnd_step(1'b1, 1'b0);
    check("pre_reset_prog", 32'(m_phase), 32'(P_PROG));
    hold_reset_and_check("rst_prog");
    repeat (10) rnd_step(1'b1, 1'b0);
    repeat (10) rnd_step(1'b0, 1'b0);

    @(posedge fpga_clk);
    #3;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
